// File: rtl/overlay_read_scheduler.sv
// Overlay read scheduler: fetches a rectangular overlay window from a single-port image RAM in
// raster order, interleaving host writes on idle cycles. Define OVERLAY_COLORKEY_EN for colour-key
// transparency (24'hFF00FF).
module overlay_read_scheduler #(
    parameter int unsigned OVL_X  = 64,
    parameter int unsigned OVL_Y  = 64,
    parameter int unsigned OVL_W  = 256,
    parameter int unsigned OVL_H  = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              pixelClock,
    input  logic              resetN,
    input  logic              deIn,
    input  logic              hsyncIn,
    input  logic              vsyncIn,
    output logic              memRe,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [23:0]       memWdata,
    input  logic [23:0]       memRdata,
    input  logic              hostReq,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [23:0]       hostData,
    output logic              hostGnt,
    output logic              deOut,
    output logic              hsyncOut,
    output logic              vsyncOut,
    output logic              overlayValid,
    output logic [23:0]       overlayPixel
);

    localparam int unsigned       Area    = OVL_W * OVL_H;
    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(Area - 1);
    localparam logic [12:0]       XLo     = 13'(OVL_X);
    localparam logic [12:0]       XHi     = 13'(OVL_X + OVL_W);
    localparam logic [12:0]       YLo     = 13'(OVL_Y);
    localparam logic [12:0]       YHi     = 13'(OVL_Y + OVL_H);

    typedef enum logic [1:0] {
        FrameWait,
        Blank,
        Line
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              deInPrev;
    logic              vsyncInPrev;
    logic              deFall;
    logic              vsRise;
    logic [11:0]       xCount;
    logic [11:0]       yCount;
    logic              inWindow;
    logic              fetch;
    logic              grant;
    logic [ADDR_W-1:0] fetchPtr;
    logic [2:0]        timingPipe1;
    logic [2:0]        timingPipe2;
    logic              validPipe;
    logic              keyHit;

    assign deFall = deInPrev & ~deIn;
    assign vsRise = vsyncIn & ~vsyncInPrev;

    assign inWindow = deIn
                      & ({1'b0, xCount} >= XLo) & ({1'b0, xCount} < XHi)
                      & ({1'b0, yCount} >= YLo) & ({1'b0, yCount} < YHi);

    // The first active pixel of a line is sampled while still in Blank, so fetch there too.
    assign fetch = inWindow & (state != FrameWait);

    // Skip the cycle after a grant so a host that drops its request on seeing hostGnt
    // is not granted twice.
    assign grant = hostReq & ~fetch & ~hostGnt;

    always_comb begin
        stateNext = state;
        unique case (state)
            FrameWait: if (vsRise) stateNext = Blank;
            Blank:     if (deIn) stateNext = Line;
            Line:      if (!deIn) stateNext = Blank;
            default:   stateNext = FrameWait;
        endcase
        if (vsRise) stateNext = Blank;
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state       <= FrameWait;
            deInPrev    <= 1'b0;
            vsyncInPrev <= 1'b0;
            xCount      <= '0;
            yCount      <= '0;
            fetchPtr    <= '0;
        end else begin
            state       <= stateNext;
            deInPrev    <= deIn;
            vsyncInPrev <= vsyncIn;

            if (deFall) begin
                xCount <= '0;
            end else if (deIn && xCount != 12'hFFF) begin
                xCount <= xCount + 12'd1;
            end

            if (vsRise) begin
                yCount <= '0;
            end else if (deFall && yCount != 12'hFFF) begin
                yCount <= yCount + 12'd1;
            end

            if (vsRise) begin
                fetchPtr <= '0;
            end else if (fetch) begin
                fetchPtr <= (fetchPtr == PtrLast) ? '0 : fetchPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            memRe       <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            hostGnt     <= 1'b0;
            timingPipe1 <= '0;
            timingPipe2 <= '0;
            validPipe   <= 1'b0;
        end else begin
            memRe       <= fetch;
            memWe       <= grant;
            hostGnt     <= grant;
            memAddr     <= fetch ? fetchPtr : (grant ? hostAddr : '0);
            memWdata    <= grant ? hostData : '0;
            timingPipe1 <= {deIn, hsyncIn, vsyncIn};
            timingPipe2 <= timingPipe1;
            // RAM data returns the cycle after memRe, lining up with the second timing stage.
            validPipe   <= memRe;
        end
    end

    assign {deOut, hsyncOut, vsyncOut} = timingPipe2;

`ifdef OVERLAY_COLORKEY_EN
    assign keyHit = (memRdata == 24'hFF00FF);
`else
    assign keyHit = 1'b0;
`endif

    assign overlayValid = validPipe & ~keyHit;
    assign overlayPixel = overlayValid ? memRdata : 24'h000000;

endmodule

// File: tb/tb_overlay_read_scheduler.sv
// Directed bench for overlay_read_scheduler: 16x4 frames, 4x2 window at (2,1), behavioural RAM.
module tb_overlay_read_scheduler;

    localparam int unsigned AddrW = 8;

    logic             pixelClock = 1'b0;
    logic             resetN;
    logic             deIn, hsyncIn, vsyncIn;
    logic             memRe, memWe;
    logic [AddrW-1:0] memAddr;
    logic [23:0]      memWdata, memRdata;
    logic             hostReq;
    logic [AddrW-1:0] hostAddr;
    logic [23:0]      hostData;
    logic             hostGnt;
    logic             deOut, hsyncOut, vsyncOut, overlayValid;
    logic [23:0]      overlayPixel;

    int checks   = 0;
    int failures = 0;

    bit          prevDe, prevHs, prevVs, prevValid;
    logic [23:0] prevPix;
    bit          wrote5;
    logic [23:0] mem [0:255];

    always #5 pixelClock = ~pixelClock;

    always @(posedge pixelClock) begin
        if (memRe) memRdata <= mem[memAddr];
        if (memWe) mem[memAddr] <= memWdata;
    end

    overlay_read_scheduler #(
        .OVL_X (2),
        .OVL_Y (1),
        .OVL_W (4),
        .OVL_H (2),
        .ADDR_W(AddrW)
    ) dut (
        .pixelClock  (pixelClock),
        .resetN      (resetN),
        .deIn        (deIn),
        .hsyncIn     (hsyncIn),
        .vsyncIn     (vsyncIn),
        .memRe       (memRe),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memRdata    (memRdata),
        .hostReq     (hostReq),
        .hostAddr    (hostAddr),
        .hostData    (hostData),
        .hostGnt     (hostGnt),
        .deOut       (deOut),
        .hsyncOut    (hsyncOut),
        .vsyncOut    (vsyncOut),
        .overlayValid(overlayValid),
        .overlayPixel(overlayPixel)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [23:0] pixOf(input int a);
        if (a == 5 && wrote5) return 24'h123456;
        if (a == 3) return 24'hFF00FF;
        if (a == 4) return 24'hFF00FE;
        return 24'hA00000 + 24'(a);
    endfunction

    function automatic bit keyOn();
`ifdef OVERLAY_COLORKEY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One pixel cycle: drive inputs, then check the registered results of this drive and the
    // two-cycle-delayed results of the previous drive.
    task automatic tick(input bit de, input bit hs, input bit vs, input bit win, input int addr,
                        input bit gnt);
        logic [23:0] pix;
        deIn    = de;
        hsyncIn = hs;
        vsyncIn = vs;
        @(posedge pixelClock);
        #1;
        checkVal("memRe", memRe, win);
        checkVal("memWe", memWe, gnt);
        checkVal("hostGnt", hostGnt, gnt);
        if (win) checkVal("fetchAddr", memAddr, addr);
        if (gnt) begin
            checkVal("hostWrAddr", memAddr, hostAddr);
            checkVal("hostWrData", memWdata, hostData);
        end
        checkVal("reWeExclusive", memRe & memWe, 0);
        checkVal("deOut", deOut, prevDe);
        checkVal("hsyncOut", hsyncOut, prevHs);
        checkVal("vsyncOut", vsyncOut, prevVs);
        checkVal("overlayValid", overlayValid, prevValid);
        checkVal("overlayPixel", overlayPixel, prevPix);
        pix       = pixOf(addr);
        prevDe    = de;
        prevHs    = hs;
        prevVs    = vs;
        prevValid = win && !(keyOn() && pix == 24'hFF00FF);
        prevPix   = prevValid ? pix : 24'h0;
    endtask

    task automatic hblank();
        for (int i = 0; i < 6; i++) tick(1'b0, (i == 2 || i == 3), 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, (i == 1 || i == 2), 1'b0, 0, 1'b0);
    endtask

    // Line l with n active pixels; act says whether fetching is expected; host request raised
    // at column reqX (or never if negative) and dropped once granted.
    task automatic line(input int l, input int n, input bit act, input int reqX, input bit tail);
        bit win;
        bit g;
        for (int p = 0; p < n; p++) begin
            win = act && l >= 1 && l <= 2 && p >= 2 && p <= 5;
            if (p == reqX) hostReq = 1'b1;
            g = hostReq && !win;
            tick(1'b1, 1'b0, 1'b0, win, (l - 1) * 4 + (p - 2), g);
            if (g) hostReq = 1'b0;
        end
        if (tail) hblank();
    endtask

    task automatic frame(input bit act);
        for (int l = 0; l < 4; l++) line(l, 16, act, -1, 1'b1);
    endtask

    initial begin
        resetN   = 1'b0;
        deIn     = 1'b1;
        hsyncIn  = 1'b0;
        vsyncIn  = 1'b1;
        hostReq  = 1'b1;
        hostAddr = 8'd20;
        hostData = 24'h777777;
        wrote5   = 1'b0;
        prevDe = 0; prevHs = 0; prevVs = 0; prevValid = 0; prevPix = '0;
        for (int i = 0; i < 256; i++) mem[i] = pixOf(i);

        repeat (3) @(posedge pixelClock);
        #1;
        checkVal("rstMemRe", memRe, 0);
        checkVal("rstMemWe", memWe, 0);
        checkVal("rstMemAddr", memAddr, 0);
        checkVal("rstMemWdata", memWdata, 0);
        checkVal("rstHostGnt", hostGnt, 0);
        checkVal("rstDeOut", deOut, 0);
        checkVal("rstHsyncOut", hsyncOut, 0);
        checkVal("rstVsyncOut", vsyncOut, 0);
        checkVal("rstOvlValid", overlayValid, 0);
        checkVal("rstOvlPixel", overlayPixel, 0);
        deIn    = 1'b0;
        vsyncIn = 1'b0;
        hostReq = 1'b0;
        resetN  = 1'b1;

        // Partial frame before any vsync: nothing fetched.
        frame(1'b0);
        vblank(5);
        // First full frame, host contention on line 1 from x=2.
        line(0, 16, 1'b1, -1, 1'b1);
        line(1, 16, 1'b1, 2, 1'b1);
        line(2, 16, 1'b1, -1, 1'b1);
        line(3, 16, 1'b1, -1, 1'b1);
        // Blanking write to address 5.
        hostAddr = 8'd5;
        hostData = 24'h123456;
        hostReq  = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        hostReq  = 1'b0;
        wrote5   = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Partial frame, then vsync must restart the pointer and line counter.
        vblank(5);
        line(0, 16, 1'b1, -1, 1'b1);
        line(1, 4, 1'b1, -1, 1'b1);
        vblank(5);
        frame(1'b1);
        vblank(5);
        // Reset mid-line while a host write grant is in flight.
        line(0, 16, 1'b1, -1, 1'b1);
        line(1, 7, 1'b1, 5, 1'b0);
        hostReq = 1'b1;
        resetN  = 1'b0;
        #1;
        checkVal("midRstMemRe", memRe, 0);
        checkVal("midRstMemWe", memWe, 0);
        checkVal("midRstHostGnt", hostGnt, 0);
        checkVal("midRstMemAddr", memAddr, 0);
        checkVal("midRstMemWdata", memWdata, 0);
        checkVal("midRstDeOut", deOut, 0);
        checkVal("midRstOvlValid", overlayValid, 0);
        checkVal("midRstOvlPixel", overlayPixel, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge pixelClock);
            #1;
            checkVal("inRstMemWe", memWe, 0);
            checkVal("inRstHostGnt", hostGnt, 0);
        end
        hostReq = 1'b0;
        deIn    = 1'b0;
        resetN  = 1'b1;
        prevDe = 0; prevHs = 0; prevVs = 0; prevValid = 0; prevPix = '0;
        // Back in frame wait: window pixels must not be fetched until the next vsync.
        line(1, 16, 1'b0, -1, 1'b1);
        line(2, 16, 1'b0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overlay_read_scheduler.md
OVERLAY_READ_SCHEDULER -- requirements
Module: overlay_read_scheduler

Interface
REQ-001 SHALL have parameter OVL_X, default 64, overlay window left column in active pixels.
REQ-002 SHALL have parameter OVL_Y, default 64, overlay window top line in active lines.
REQ-003 SHALL have parameter OVL_W, default 256, overlay window width in pixels.
REQ-004 SHALL have parameter OVL_H, default 256, overlay window height in lines.
REQ-005 SHALL have parameter ADDR_W, default 16, image RAM address width; OVL_W*OVL_H SHALL not exceed 2^ADDR_W.
REQ-006 SHALL have ports: pixelClock in 1, pixel clock, the only clock; resetN in 1, asynchronous active-low reset.
REQ-007 SHALL have ports deIn, hsyncIn, vsyncIn, each in 1: timing from the HDMI timing generator, vsync active high.
REQ-008 SHALL have ports memRe out 1, memWe out 1, memAddr out ADDR_W, memWdata out 24, memRdata in 24: single-port image RAM, read data valid 1 cycle after memRe.
REQ-009 SHALL have ports hostReq in 1, hostAddr in ADDR_W, hostData in 24, hostGnt out 1: host write requester.
REQ-010 SHALL have ports deOut, hsyncOut, vsyncOut out 1 (delayed timing) and overlayValid out 1, overlayPixel out 24.

Function
REQ-011 SHALL keep column counter x (12 bit): increments per deIn-high cycle, clears to 0 on deIn falling edge, saturates at 4095.
REQ-012 SHALL keep line counter y (12 bit): increments on deIn falling edge, clears to 0 on vsyncIn rising edge, saturates at 4095.
REQ-013 SHALL define inWindow = deIn & OVL_X<=x<OVL_X+OVL_W & OVL_Y<=y<OVL_Y+OVL_H, evaluated on the cycle deIn is sampled.
REQ-014 SHALL use FSM states FRAME_WAIT, BLANK, LINE: reset->FRAME_WAIT; FRAME_WAIT->BLANK on first vsyncIn rising edge; BLANK->LINE on deIn high; LINE->BLANK on deIn low; any state->BLANK on vsyncIn rising edge.
REQ-015 SHALL issue no fetch in FRAME_WAIT; overlayValid SHALL stay 0 until the first full frame.
REQ-016 SHALL, when inWindow in LINE, register memRe=1, memWe=0, memAddr=fetch pointer on the next cycle; fetch pointer increments per fetch and clears on vsyncIn rising edge and on reaching OVL_W*OVL_H.
REQ-017 SHALL grant host writes on any cycle with no fetch issued: memWe=1, memAddr=hostAddr, memWdata=hostData, hostGnt=1 for exactly that one cycle.
REQ-018 SHALL give fetch strict priority: simultaneous hostReq and inWindow -> fetch issued, hostGnt=0, request retained by host.
REQ-019 SHALL never assert memRe and memWe together.
REQ-020 SHALL delay deIn/hsyncIn/vsyncIn by exactly 2 cycles onto deOut/hsyncOut/vsyncOut.
REQ-021 SHALL assert overlayValid and drive overlayPixel=memRdata 2 cycles after the inWindow sample, aligned with deOut; else overlayValid=0, overlayPixel=0.
REQ-022 SHALL serve a host request held through any blanking cycle within at most 2 cycles of that cycle.

Reset
REQ-023 SHALL on resetN low asynchronously clear all outputs to 0, counters and fetch pointer to 0, delay pipeline to 0, FSM to FRAME_WAIT.
REQ-024 SHALL abort an in-flight host write on reset mid-operation: hostGnt returns 0, no further memWe until resetN high.
REQ-025 SHALL leave reset synchronously on the first pixelClock rising edge after resetN rises.

Configuration
REQ-026 SHALL, with OVERLAY_COLORKEY_EN defined, force overlayValid=0 when memRdata equals 24'hFF00FF (transparent key), pixel pipeline timing unchanged.
REQ-027 SHALL, without OVERLAY_COLORKEY_EN, assert overlayValid for every in-window pixel regardless of data.

Verification
REQ-028 Reset: resetN low mid-line -> all outputs 0 same cycle, FSM FRAME_WAIT, no memRe before next vsyncIn rise.
REQ-029 Window fetch (OVL_X=2, OVL_Y=1, OVL_W=4, OVL_H=2, 16x4 frame): second frame -> memRe on 8 cycles, addresses 0..7, overlayValid high x=2..5 lines 1..2, 2 cycles after deIn.
REQ-030 Contention: hostReq held from x=2 of line 1 -> hostGnt=0 while fetching, single hostGnt pulse at first non-window cycle (x=6), memWe never with memRe.
REQ-031 Blanking write: hostReq with hostAddr=5, hostData=24'h123456 in blanking -> memWe=1, memAddr=5, memWdata=24'h123456, hostGnt=1 for one cycle.
REQ-032 Pointer wrap: vsyncIn rising edge after partial frame -> next fetch address 0, y=0.
REQ-033 Colour key (macro defined): memRdata=24'hFF00FF at window pixel -> overlayValid=0 that cycle; with 24'hFF00FE -> overlayValid=1.
